axi4_mem_responder: RTL and testbench
=====================================

Name: axi4_mem_responder

Overview:
AXI4 slave memory model: the responder end of the driver's main/sub AXI4 master ports, used in sim and on-board loopback tests. It accepts INCR/FIXED bursts into a DATA_WIDTH-wide synchronous RAM, with one outstanding write and one outstanding read. The write and read channels are independent FSMs.

Parameters:
ADDR_WIDTH, 34, byte address width (matches MAIN/SUB_ADDR_WIDTH)
DATA_WIDTH, 128, data bus width; 32/64/128/256 legal
MEM_DEPTH, 1024, RAM depth in DATA_WIDTH words; power of two

Ports:
clk  in  1  single clock
rstn  in  1  synchronous active-low reset
awaddr  in  ADDR_WIDTH  write burst start byte address
awlen  in  8  beats-1
awsize  in  3  accepted, ignored (full-width beats only)
awburst  in  2  00 FIXED, 01 INCR, 10 WRAP (treated as INCR), 11 reserved
awvalid  in  1  AW valid
awready  out  1  AW ready
wdata  in  DATA_WIDTH  write data
wstrb  in  DATA_WIDTH/8  byte enables
wlast  in  1  last write beat
wvalid  in  1  W valid
wready  out  1  W ready
bresp  out  2  write response
bvalid  out  1  B valid
bready  in  1  B ready
araddr  in  ADDR_WIDTH  read burst start byte address
arlen  in  8  beats-1
arsize  in  3  accepted, ignored
arburst  in  2  same encoding as awburst
arvalid  in  1  AR valid
arready  out  1  AR ready
rdata  out  DATA_WIDTH  read data
rresp  out  2  read response
rlast  out  1  last read beat
rvalid  out  1  R valid
rready  in  1  R ready

Behaviour:
- Reset (rstn=0 at posedge): all outputs 0, both FSMs idle. RAM contents are not reset. awready/arready first go 1 in the cycle after rstn returns to 1. Reset mid-burst aborts the burst; no B/R response is issued for it.
- Word index = addr[log2(DATA_WIDTH/8) +: log2(MEM_DEPTH)]; low byte bits ignored; upper bits ignored, so addresses alias modulo MEM_DEPTH. The index increments by 1 per beat for INCR/WRAP, stays constant for FIXED, and wraps from MEM_DEPTH-1 to 0.
- Write FSM W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: awready=1; on the AW handshake, latch the address and burst type; go to W_DATA.
  - W_DATA: wready=1; each accepted beat writes the bytes enabled by wstrb in the same cycle. The beat with wlast=1 moves to W_RESP, regardless of awlen (awlen is not checked).
  - W_RESP: bvalid=1 with bresp held stable until bready; return to W_IDLE on handshake.
- Reserved burst (11): no RAM writes for the burst; bresp/rresp=SLVERR (10) on all responses for that burst. Otherwise OKAY (00).
- Read FSM R_IDLE -> R_DATA:
  - R_IDLE: arready=1; on the AR handshake, latch the address, len, and type.
  - R_DATA: first rvalid 2 cycles after the AR handshake. Beats are back-to-back while rready=1, using a 2-entry prefetch buffer.
  - rdata/rresp/rlast are held stable while rvalid=1 and rready=0. rlast=1 on beat arlen. After that beat's handshake, return to R_IDLE; arready is high in the next cycle.
- Write and read bursts overlap freely. If a same-word write and RAM read occur in the same cycle, the read returns the old data.

Test Plan:
- Reset then INCR write of 4 beats at addr 0x100 (data 0xA0..0xA3, wstrb all 1) -> bresp=00 once. An INCR read of 4 beats from 0x100 with rready=1 -> beats A0,A1,A2,A3 on consecutive cycles, rlast only on the 4th, first rvalid 2 cycles after AR.
- Write wstrb=0x000F data 0xFFFF... to word 5 (pre-filled with 0) -> a read of word 5 returns 0x...0000FFFFFFFF.
- Read of 8 beats with rready toggled 1,0,0,1 -> no beat lost or duplicated; rdata stable across stalls.
- FIXED write of 3 beats to word 7 with data 1,2,3 -> word 7 = 3, and words 8 and 9 are unchanged.
- INCR 2 beats at word MEM_DEPTH-1 -> second beat lands in word 0. An awburst=11 write -> bresp=10 and RAM is unchanged.
- Assert rstn=0 mid-read after 2 of 4 beats -> rvalid=0 next cycle, no further beats, and arready=1 one cycle after reset release.

Source files
------------

// File: rtl/axi4_mem_responder_if.sv
// AXI4 bundle between a master and axi4_mem_responder.
// Handshake rule on every channel: a transfer happens on the rising clk edge
// where valid and ready are both 1; the sender holds its payload stable and
// keeps valid high until that edge, and never waits for ready to raise valid.
interface axi4_mem_responder_if #(
   parameter int ADDR_WIDTH = 34,
   parameter int DATA_WIDTH = 128
);
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [7:0]              awlen;
   logic [2:0]              awsize;
   logic [1:0]              awburst;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wlast;
   logic                    wvalid;
   logic                    wready;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic [7:0]              arlen;
   logic [2:0]              arsize;
   logic [1:0]              arburst;
   logic                    arvalid;
   logic                    arready;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rlast;
   logic                    rvalid;
   logic                    rready;

   modport slave (
      input  awaddr, awlen, awsize, awburst, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bresp, bvalid,
      input  bready,
      input  araddr, arlen, arsize, arburst, arvalid,
      output arready,
      output rdata, rresp, rlast, rvalid,
      input  rready
   );

   modport master (
      output awaddr, awlen, awsize, awburst, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bresp, bvalid,
      output bready,
      output araddr, arlen, arsize, arburst, arvalid,
      input  arready,
      input  rdata, rresp, rlast, rvalid,
      output rready
   );
endinterface

// File: rtl/axi4_mem_responder.sv
// AXI4 slave memory model: one outstanding write burst and one outstanding
// read burst into a DATA_WIDTH-wide synchronous RAM. Write and read channels
// run as independent FSMs; the read side uses a 2-entry prefetch buffer so
// beats stream back-to-back while rready stays high.
module axi4_mem_responder #(
   parameter int ADDR_WIDTH = 34,
   parameter int DATA_WIDTH = 128,
   parameter int MEM_DEPTH  = 1024
) (
   input  logic                clk,
   input  logic                rstn,
   axi4_mem_responder_if.slave axi,
   output logic [1:0]          w_state_dbg,
   output logic [1:0]          r_state_dbg
);
   localparam int STRB_W    = DATA_WIDTH / 8;
   localparam int BYTE_BITS = $clog2(STRB_W);
   localparam int IDX_BITS  = $clog2(MEM_DEPTH);

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_RSVD  = 2'b11;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // *_INIT holds the ready outputs low for the cycle that follows reset.
   typedef enum logic [1:0] {W_INIT, W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic [1:0] {R_INIT, R_IDLE, R_DATA} r_state_t;

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   // write channel
   w_state_t            w_state, w_state_nxt;
   logic [IDX_BITS-1:0] w_idx;
   logic                w_fixed, w_rsvd;
   logic                aw_hs, w_hs, w_en;

   // read channel
   r_state_t            r_state, r_state_nxt;
   logic [IDX_BITS-1:0] r_idx;
   logic [7:0]          r_len;
   logic [7:0]          r_cnt;      // beats already handed to the master
   logic [8:0]          r_iss;      // beats already fetched from RAM
   logic                r_fixed, r_rsvd;
   logic [DATA_WIDTH-1:0] buf_q [2];
   logic                buf_wp, buf_rp;
   logic [1:0]          buf_cnt;
   logic                ar_hs, r_avail, r_pop, r_last_pop, r_more, r_issue;

   // Size fields and address bits outside the word index carry no meaning here.
   logic unused_bits;
   assign unused_bits = ^{axi.awsize, axi.arsize, axi.awaddr, axi.araddr};

   assign w_state_dbg = w_state;
   assign r_state_dbg = r_state;

   assign aw_hs = axi.awvalid && (w_state == W_IDLE);
   assign w_hs  = axi.wvalid  && (w_state == W_DATA);
   // Reserved bursts are consumed but never touch the RAM.
   assign w_en  = w_hs && !w_rsvd && rstn;

   assign axi.bresp = (w_state == W_RESP && w_rsvd) ? RESP_SLVERR : RESP_OKAY;

   // Write FSM state register.
   always_ff @(posedge clk) begin
      if (!rstn) w_state <= W_INIT;
      else       w_state <= w_state_nxt;
   end

   // Write FSM next state and handshake outputs; wlast alone ends the burst.
   always_comb begin
      w_state_nxt = w_state;
      axi.awready = 1'b0;
      axi.wready  = 1'b0;
      axi.bvalid  = 1'b0;
      case (w_state)
         W_INIT: w_state_nxt = W_IDLE;
         W_IDLE: begin
            axi.awready = 1'b1;
            if (axi.awvalid) w_state_nxt = W_DATA;
         end
         W_DATA: begin
            axi.wready = 1'b1;
            if (axi.wvalid && axi.wlast) w_state_nxt = W_RESP;
         end
         W_RESP: begin
            axi.bvalid = 1'b1;
            if (axi.bready) w_state_nxt = W_IDLE;
         end
         default: w_state_nxt = W_IDLE;
      endcase
   end

   // Write address tracking: latch on AW, step per beat unless FIXED.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         w_idx   <= '0;
         w_fixed <= 1'b0;
         w_rsvd  <= 1'b0;
      end else if (aw_hs) begin
         w_idx   <= axi.awaddr[BYTE_BITS +: IDX_BITS];
         w_fixed <= (axi.awburst == BURST_FIXED);
         w_rsvd  <= (axi.awburst == BURST_RSVD);
      end else if (w_hs && !w_fixed) begin
         w_idx <= w_idx + 1'b1;
      end
   end

   assign ar_hs      = axi.arvalid && (r_state == R_IDLE);
   assign r_avail    = (r_state == R_DATA) && (buf_cnt != 2'd0);
   assign r_pop      = r_avail && axi.rready;
   assign r_last_pop = r_pop && (r_cnt == r_len);
   assign r_more     = (r_iss <= {1'b0, r_len});
   // Fetch while beats remain and the buffer has (or is freeing) a slot.
   assign r_issue    = (r_state == R_DATA) && r_more && ((buf_cnt != 2'd2) || r_pop);

   assign axi.rvalid = r_avail;
   assign axi.rdata  = r_avail ? buf_q[buf_rp] : '0;
   assign axi.rresp  = (r_avail && r_rsvd) ? RESP_SLVERR : RESP_OKAY;
   assign axi.rlast  = r_avail && (r_cnt == r_len);

   // Read FSM state register.
   always_ff @(posedge clk) begin
      if (!rstn) r_state <= R_INIT;
      else       r_state <= r_state_nxt;
   end

   // Read FSM next state; the burst ends on the handshake of beat arlen.
   always_comb begin
      r_state_nxt = r_state;
      axi.arready = 1'b0;
      case (r_state)
         R_INIT: r_state_nxt = R_IDLE;
         R_IDLE: begin
            axi.arready = 1'b1;
            if (axi.arvalid) r_state_nxt = R_DATA;
         end
         R_DATA: if (r_last_pop) r_state_nxt = R_IDLE;
         default: r_state_nxt = R_IDLE;
      endcase
   end

   // Read burst bookkeeping and prefetch buffer pointers.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_idx   <= '0;
         r_len   <= '0;
         r_cnt   <= '0;
         r_iss   <= '0;
         r_fixed <= 1'b0;
         r_rsvd  <= 1'b0;
         buf_wp  <= 1'b0;
         buf_rp  <= 1'b0;
         buf_cnt <= '0;
      end else if (ar_hs) begin
         r_idx   <= axi.araddr[BYTE_BITS +: IDX_BITS];
         r_len   <= axi.arlen;
         r_cnt   <= '0;
         r_iss   <= '0;
         r_fixed <= (axi.arburst == BURST_FIXED);
         r_rsvd  <= (axi.arburst == BURST_RSVD);
      end else begin
         if (r_issue) begin
            r_iss  <= r_iss + 1'b1;
            buf_wp <= ~buf_wp;
            if (!r_fixed) r_idx <= r_idx + 1'b1;
         end
         if (r_pop) begin
            r_cnt  <= r_cnt + 1'b1;
            buf_rp <= ~buf_rp;
         end
         case ({r_issue, r_pop})
            2'b10:   buf_cnt <= buf_cnt + 1'b1;
            2'b01:   buf_cnt <= buf_cnt - 1'b1;
            default: buf_cnt <= buf_cnt;
         endcase
      end
   end

   // RAM: byte-enabled write port and a registered read into the prefetch
   // buffer; a same-cycle read of the word being written sees the old data.
   always_ff @(posedge clk) begin
      if (w_en) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (axi.wstrb[b]) mem[w_idx][b*8 +: 8] <= axi.wdata[b*8 +: 8];
         end
      end
      if (r_issue) buf_q[buf_wp] <= mem[r_idx];
   end
endmodule

// File: tb/tb_axi4_mem_responder.sv
// Directed bench for axi4_mem_responder: linear sequence of AXI bursts with
// hand-computed expected data held in a scoreboard queue.
module tb_axi4_mem_responder;
   localparam int AW  = 34;
   localparam int DW  = 128;
   localparam int SW  = DW / 8;
   localparam int TMO = 64;

   // clock / reset
   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   axi4_mem_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi();
   logic [1:0] w_state_dbg, r_state_dbg;

   axi4_mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(1024)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .axi         (axi),
      .w_state_dbg (w_state_dbg),
      .r_state_dbg (r_state_dbg)
   );

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] got_q[$];
   logic          got_last_q[$];
   logic [1:0]    got_resp_q[$];
   int            got_cyc_q[$];

   logic [DW-1:0] wd [16];
   logic [SW-1:0] ws [16];
   logic          rr_pat [4];
   logic [1:0]    resp;
   logic [DW-1:0] d;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic timeout(input string tag);
      total++;
      bad++;
      $display("FAIL %s timeout observed=none expected=handshake", tag);
   endtask

   function automatic logic [AW-1:0] wa(input int idx);
      return AW'(idx) << 4;
   endfunction

   // driver: one write burst using wd/ws; returns bresp
   task automatic axi_write(input logic [AW-1:0] addr, input int nbeats,
                            input logic [1:0] burst, output logic [1:0] rsp);
      int n;
      axi.awaddr = addr; axi.awlen = 8'(nbeats - 1); axi.awsize = 3'd4;
      axi.awburst = burst; axi.awvalid = 1'b1;
      n = 0;
      while (axi.awready !== 1'b1 && n < TMO) begin @(posedge clk); #1; n++; end
      if (n >= TMO) timeout("aw");
      @(posedge clk); #1;
      axi.awvalid = 1'b0;
      for (int i = 0; i < nbeats; i++) begin
         axi.wdata = wd[i]; axi.wstrb = ws[i]; axi.wlast = (i == nbeats - 1);
         axi.wvalid = 1'b1;
         n = 0;
         while (axi.wready !== 1'b1 && n < TMO) begin @(posedge clk); #1; n++; end
         if (n >= TMO) timeout("w");
         @(posedge clk); #1;
      end
      axi.wvalid = 1'b0; axi.wlast = 1'b0;
      axi.bready = 1'b1;
      n = 0;
      while (axi.bvalid !== 1'b1 && n < TMO) begin @(posedge clk); #1; n++; end
      if (n >= TMO) timeout("b");
      rsp = axi.bresp;
      @(posedge clk); #1;
      axi.bready = 1'b0;
   endtask

   // driver + monitor: one read burst, rready from rr_pat; cycle 1 is the
   // cycle right after the AR handshake. abort_after>0 stops after that many beats.
   task automatic axi_read(input logic [AW-1:0] addr, input int nbeats,
                           input logic [1:0] burst, input int abort_after);
      int n, k, got;
      logic held_v;
      logic [DW-1:0] held_d;
      got_q.delete(); got_last_q.delete(); got_resp_q.delete(); got_cyc_q.delete();
      axi.araddr = addr; axi.arlen = 8'(nbeats - 1); axi.arsize = 3'd4;
      axi.arburst = burst; axi.arvalid = 1'b1;
      n = 0;
      while (axi.arready !== 1'b1 && n < TMO) begin @(posedge clk); #1; n++; end
      if (n >= TMO) timeout("ar");
      @(posedge clk); #1;
      axi.arvalid = 1'b0;
      k = 1; got = 0; held_v = 1'b0; held_d = '0;
      while (got < nbeats && k < 200) begin
         axi.rready = rr_pat[(k - 1) % 4];
         if (held_v) begin
            check("r_hold_valid", DW'(axi.rvalid), DW'(1));
            check("r_stable", axi.rdata, held_d);
         end
         held_v = axi.rvalid && !axi.rready;
         held_d = axi.rdata;
         if (axi.rvalid === 1'b1 && axi.rready) begin
            got_q.push_back(axi.rdata);
            got_last_q.push_back(axi.rlast);
            got_resp_q.push_back(axi.rresp);
            got_cyc_q.push_back(k);
            got++;
         end
         @(posedge clk); #1;
         k++;
         if (abort_after > 0 && got == abort_after) break;
      end
      if (abort_after == 0) begin
         axi.rready = 1'b0;
         if (got < nbeats) timeout("r");
      end
   endtask

   // scoreboard: compare collected beats against exp_q in order
   task automatic score(input string tag);
      int i;
      i = 0;
      while (exp_q.size() > 0) begin
         if (got_q.size() == 0) begin
            timeout({tag, "_missing_beat"});
            exp_q.delete();
         end else begin
            check(tag, got_q.pop_front(), exp_q.pop_front());
         end
         i++;
      end
      check({tag, "_extra_beats"}, DW'(got_q.size()), DW'(0));
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog observed=hang expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0; axi.awburst = '0; axi.awvalid = 1'b0;
      axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0; axi.bready = 1'b0;
      axi.araddr = '0; axi.arlen = '0; axi.arsize = '0; axi.arburst = '0; axi.arvalid = 1'b0;
      axi.rready = 1'b0;
      rr_pat = '{1'b1, 1'b1, 1'b1, 1'b1};

      // reset: all outputs low, readies rise one cycle after release
      rstn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_awready", DW'(axi.awready), DW'(0));
      check("rst_arready", DW'(axi.arready), DW'(0));
      check("rst_bvalid",  DW'(axi.bvalid),  DW'(0));
      check("rst_rvalid",  DW'(axi.rvalid),  DW'(0));
      check("rst_wready",  DW'(axi.wready),  DW'(0));
      rstn = 1'b1;
      check("rel_awready_low", DW'(axi.awready), DW'(0));
      @(posedge clk); #1;
      check("rel_awready", DW'(axi.awready), DW'(1));
      check("rel_arready", DW'(axi.arready), DW'(1));

      // INCR 4 beats at 0x100 (word 16)
      for (int i = 0; i < 4; i++) begin wd[i] = DW'(8'hA0 + i); ws[i] = '1; end
      axi_write(34'h100, 4, 2'b01, resp);
      check("incr_bresp", DW'(resp), DW'(0));
      check("bvalid_once", DW'(axi.bvalid), DW'(0));
      axi_read(34'h100, 4, 2'b01, 0);
      for (int i = 0; i < got_cyc_q.size(); i++) begin
         check("incr_rcycle", DW'(got_cyc_q[i]), DW'(2 + i));
         check("incr_rlast", DW'(got_last_q[i]), DW'(i == 3));
         check("incr_rresp", DW'(got_resp_q[i]), DW'(0));
      end
      for (int i = 0; i < 4; i++) exp_q.push_back(DW'(8'hA0 + i));
      score("incr_rdata");
      check("r_idle_after", DW'(axi.arready), DW'(1));

      // partial strobe on word 5
      wd[0] = '0; ws[0] = '1;
      axi_write(wa(5), 1, 2'b01, resp);
      wd[0] = '1; ws[0] = SW'(16'h000F);
      axi_write(wa(5), 1, 2'b01, resp);
      axi_read(wa(5), 1, 2'b01, 0);
      exp_q.push_back(128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF);
      score("strb_rdata");

      // 8-beat read with rready 1,0,0,1
      for (int i = 0; i < 8; i++) begin wd[i] = DW'(32'h1000 + i) << 64; ws[i] = '1; end
      axi_write(wa(32), 8, 2'b01, resp);
      rr_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
      axi_read(wa(32), 8, 2'b01, 0);
      check("stall_last", DW'(got_last_q.size() == 8 ? got_last_q[7] : 1'b0), DW'(1));
      for (int i = 0; i < 8; i++) exp_q.push_back(DW'(32'h1000 + i) << 64);
      score("stall_rdata");
      rr_pat = '{1'b1, 1'b1, 1'b1, 1'b1};

      // FIXED write of 1,2,3 to word 7; words 8 and 9 untouched
      wd[0] = 128'h77; wd[1] = 128'h88; wd[2] = 128'h99;
      for (int i = 0; i < 3; i++) ws[i] = '1;
      axi_write(wa(7), 3, 2'b01, resp);
      for (int i = 0; i < 3; i++) wd[i] = DW'(i + 1);
      axi_write(wa(7), 3, 2'b00, resp);
      check("fixed_bresp", DW'(resp), DW'(0));
      axi_read(wa(7), 3, 2'b01, 0);
      exp_q.push_back(128'h3); exp_q.push_back(128'h88); exp_q.push_back(128'h99);
      score("fixed_rdata");

      // INCR wrap from word 1023 to word 0
      wd[0] = 128'hD0; wd[1] = 128'hD1; ws[0] = '1; ws[1] = '1;
      axi_write(wa(1023), 2, 2'b01, resp);
      axi_read(wa(1023), 2, 2'b01, 0);
      exp_q.push_back(128'hD0); exp_q.push_back(128'hD1);
      score("wrap_rdata");
      axi_read(wa(0), 1, 2'b00, 0);
      exp_q.push_back(128'hD1);
      score("wrap_word0");

      // reserved write: SLVERR, RAM unchanged; aliased reserved read: SLVERR
      wd[0] = 128'hBAD; ws[0] = '1;
      axi_write(wa(16), 1, 2'b11, resp);
      check("rsvd_bresp", DW'(resp), DW'(2));
      axi_read(34'h2_0000_0100, 1, 2'b11, 0);
      check("rsvd_rresp", DW'(got_resp_q.size() > 0 ? got_resp_q[0] : 2'b00), DW'(2));
      exp_q.push_back(128'hA0);
      score("rsvd_alias_rdata");

      // reset after 2 of 4 read beats
      axi_read(34'h100, 4, 2'b01, 2);
      exp_q.push_back(128'hA0); exp_q.push_back(128'hA1);
      score("abort_rdata");
      rstn = 1'b0;
      @(posedge clk); #1;
      check("abort_rvalid", DW'(axi.rvalid), DW'(0));
      check("abort_arready", DW'(axi.arready), DW'(0));
      @(posedge clk); #1;
      rstn = 1'b1;
      axi.rready = 1'b0;
      check("abort_rel_arready_low", DW'(axi.arready), DW'(0));
      @(posedge clk); #1;
      check("abort_rel_arready", DW'(axi.arready), DW'(1));
      for (int i = 0; i < 3; i++) begin
         check("abort_no_beats", DW'(axi.rvalid), DW'(0));
         @(posedge clk); #1;
      end
      d = '0;
      check("abort_bvalid", DW'(axi.bvalid), d);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
